// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: FSM state encoding and Memory R_W encoding shared by mem_req_ctrl; VRD_* states exist only with MEM_REQ_CTRL_VERIFY_EN
package mem_ctrl_pkg;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_RD = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;
`ifdef MEM_REQ_CTRL_VERIFY_EN
  localparam logic [2:0] S_VRD_ISSUE = 3'd4;
  localparam logic [2:0] S_VRD_WAIT  = 3'd5;
`endif
endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: synchronous request FIFO; ports clk, rst, push/wdata in, pop in, rdata (head), full, empty
module mem_req_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!rst && push && !full) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: queues client read/write requests and issues them one at a time to Memory; returns read data on a valid/ready channel
// Ports: Clk/Reset; Req* client request channel; Rsp* read response channel; Mem* to/from Memory; Busy; VerifyErr.
// MEM_REQ_CTRL_VERIFY_EN: read back every write and set sticky VerifyErr on mismatch; otherwise VerifyErr is 0.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DinLength  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqRW,
  input  logic [WIDTH-1:0]     ReqAddr,
  input  logic [DinLength-1:0] ReqData,
  output logic                 RspValid,
  input  logic                 RspReady,
  output logic [DinLength-1:0] RspData,
  output logic [DinLength-1:0] MemDin,
  output logic [WIDTH-1:0]     MemAddr,
  output logic                 MemR_W,
  output logic                 MemValid,
  input  logic [DinLength-1:0] MemDout,
  output logic                 Busy,
  output logic                 VerifyErr
);
  localparam int EW = 1 + WIDTH + DinLength;
  logic [2:0] state;
  logic full, empty;
  logic [EW-1:0] head;
  assign ReqReady = !full && !Reset;
  assign Busy = !empty || state != S_IDLE;
  mem_req_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clk), .rst(Reset), .push(ReqValid && ReqReady), .pop(state == S_IDLE),
    .wdata({ReqRW, ReqAddr, ReqData}), .rdata(head), .full(full), .empty(empty)
  );
  // The Mem* outputs double as the op registers: loaded on pop, held otherwise.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      MemR_W   <= 1'b0;
      MemAddr  <= '0;
      MemDin   <= '0;
      RspValid <= 1'b0;
      RspData  <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          {MemR_W, MemAddr, MemDin} <= head;
          state <= S_ISSUE;
        end
`ifdef MEM_REQ_CTRL_VERIFY_EN
        S_ISSUE: if (MemR_W == RW_WRITE) begin
          MemR_W <= RW_READ;
          state  <= S_VRD_ISSUE;
        end else state <= S_WAIT_RD;
        S_VRD_ISSUE: state <= S_VRD_WAIT;
        S_VRD_WAIT:  state <= S_IDLE;
`else
        S_ISSUE: state <= MemR_W == RW_WRITE ? S_IDLE : S_WAIT_RD;
`endif
        S_WAIT_RD: begin
          RspData  <= MemDout;
          RspValid <= 1'b1;
          state    <= S_RESP;
        end
        S_RESP: if (RspReady) begin
          RspValid <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef MEM_REQ_CTRL_VERIFY_EN
  assign MemValid = state == S_ISSUE || state == S_VRD_ISSUE;
  always_ff @(posedge Clk) begin
    if (Reset) VerifyErr <= 1'b0;
    else if (state == S_VRD_WAIT && MemDout != MemDin) VerifyErr <= 1'b1;
  end
`else
  assign MemValid  = state == S_ISSUE;
  assign VerifyErr = 1'b0;
`endif
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: self-checking bench for mem_req_ctrl with a behavioural Memory and an in-order reference model
module tb_mem_req_ctrl;
`ifdef MEM_REQ_CTRL_VERIFY_EN
  localparam int NSTROBE = 2;
`else
  localparam int NSTROBE = 1;
`endif
  logic clk = 0, Reset = 1;
  logic ReqValid = 0, ReqReady, ReqRW = 0, RspValid, RspReady = 1, MemR_W, MemValid, Busy, VerifyErr;
  logic [7:0] ReqAddr = 0, MemAddr;
  logic [31:0] ReqData = 0, RspData, MemDin, MemDout;
  logic corrupt = 0;
  logic [31:0] tb_mem [256];
  logic [31:0] model_mem [256];
  logic [31:0] exp_q [$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_req_ctrl dut (
    .Clk(clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqRW(ReqRW),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .RspValid(RspValid), .RspReady(RspReady),
    .RspData(RspData), .MemDin(MemDin), .MemAddr(MemAddr), .MemR_W(MemR_W),
    .MemValid(MemValid), .MemDout(MemDout), .Busy(Busy), .VerifyErr(VerifyErr)
  );

  initial begin
    MemDout = 0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 32'hC0DE0000 + i;
      model_mem[i] = 32'hC0DE0000 + i;
    end
  end

  always @(posedge clk)
    if (MemValid) begin
      if (MemR_W) tb_mem[MemAddr] <= (corrupt && MemAddr == 8'h05) ? ~MemDin : MemDin;
      else MemDout <= tb_mem[MemAddr];
    end

  function automatic void check(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic void accept(logic rw, logic [7:0] a, logic [31:0] d);
    if (rw) model_mem[a] = d;
    else exp_q.push_back(model_mem[a]);
  endfunction

  always @(negedge clk)
    if (!Reset && RspValid && RspReady) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp_data", RspData, exp_q.pop_front());
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rw, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    ReqValid = 1; ReqRW = rw; ReqAddr = a; ReqData = d;
    while (!ReqReady && n < 100) begin step(); n++; end
    if (n == 100) check("push_timeout", ReqReady, 1);
    else accept(rw, a, d);
    step();
    ReqValid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((Busy || exp_q.size() != 0) && n < 300) begin step(); n++; end
    check("drain_busy", Busy, 0);
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!RspValid && lat < 40) begin step(); lat++; end
  endtask

  typedef struct {
    logic rw;
    logic [7:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, cnt;
    vecs[0] = '{1'b1, 8'h00, 32'hAABBCCDD, 32'h0};
    vecs[1] = '{1'b0, 8'h00, 32'h0, 32'hAABBCCDD};
    vecs[2] = '{1'b1, 8'hFF, 32'hFFFFFFFF, 32'h0};
    vecs[3] = '{1'b0, 8'hFF, 32'h0, 32'hFFFFFFFF};
    vecs[4] = '{1'b0, 8'h03, 32'h0, 32'hC0DE0003};
    vecs[5] = '{1'b1, 8'h80, 32'h00000000, 32'h0};
    vecs[6] = '{1'b0, 8'h80, 32'h0, 32'h00000000};
    vecs[7] = '{1'b1, 8'h00, 32'h12345678, 32'h0};
    vecs[8] = '{1'b0, 8'h00, 32'h0, 32'h12345678};

    // reset
    step(); step();
    check("rst_reqready", ReqReady, 0);
    check("rst_outs", {RspValid, MemR_W, MemValid, Busy, VerifyErr}, 0);
    check("rst_rspdata", RspData, 0);
    check("rst_memdin", MemDin, 0);
    check("rst_memaddr", MemAddr, 0);
    Reset = 0;
    step();
    check("post_rst_reqready", ReqReady, 1);

    // single-request vectors: latency, strobe count and strobe contents
    foreach (vecs[i]) begin
      push(vecs[i].rw, vecs[i].a, vecs[i].d);
      if (vecs[i].rw) begin
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
          if (MemValid) begin
            if (cnt == 0) check("wr_strobe", {MemR_W, MemAddr, MemDin}, {1'b1, vecs[i].a, vecs[i].d});
            cnt++;
          end
          step();
        end
        check("wr_strobe_count", cnt, NSTROBE);
      end else begin
        wait_rsp(lat);
        check("rd_latency", lat, 4);
        check("rd_data", RspData, vecs[i].exp);
      end
      wait_idle();
    end

    // backpressure: fill queue while a response is held
    RspReady = 0;
    push(1, 8'h01, 32'h11223344);
    push(1, 8'h02, 32'h55667788);
    push(1, 8'h03, 32'h99AABBCC);
    push(0, 8'h02, 0);
    push(0, 8'h01, 0);
    wait_rsp(lat);
    check("bp_first_rsp", RspData, 32'h55667788);
    push(0, 8'h03, 0);
    push(0, 8'h01, 0);
    push(0, 8'h02, 0);
    check("bp_full_ready", ReqReady, 0);
    check("bp_busy", Busy, 1);
    ReqValid = 1; ReqRW = 1; ReqAddr = 8'h02; ReqData = 32'hBADBAD00;
    for (int k = 0; k < 3; k++) begin
      check("bp_full_hold", ReqReady, 0);
      check("bp_rsp_hold", {RspValid, RspData}, {1'b1, 32'h55667788});
      step();
    end
    ReqValid = 0;
    RspReady = 1;
    step();
    wait_rsp(lat);
    check("bp_second_rsp", RspData, 32'h11223344);
    wait_idle();

    // wrap-around: three fill/drain rounds of mixed requests
    for (int r = 0; r < 3; r++) begin
      RspReady = 0;
      for (int k = 0; k < 40 && ReqReady; k++) begin
        ReqValid = 1; ReqRW = 1'($urandom_range(0, 1));
        ReqAddr = 8'($urandom_range(0, 15)); ReqData = $urandom;
        if (ReqReady) accept(ReqRW, ReqAddr, ReqData);
        step();
      end
      ReqValid = 0;
      check("fill_full", ReqReady, 0);
      RspReady = 1;
      wait_idle();
    end

    // random traffic with random response backpressure
    for (int c = 0; c < 500; c++) begin
      ReqValid = 1'($urandom_range(0, 1)); ReqRW = 1'($urandom_range(0, 1));
      ReqAddr = 8'($urandom_range(0, 15)); ReqData = $urandom;
      RspReady = $urandom_range(0, 3) != 0;
      if (ReqValid && ReqReady) accept(ReqRW, ReqAddr, ReqData);
      step();
    end
    ReqValid = 0;
    RspReady = 1;
    wait_idle();
    check("verify_clean", VerifyErr, 0);

    // reset while a read waits for Memory data, two requests queued
    push(0, 8'h00, 0);
    push(0, 8'h01, 0);
    push(1, 8'h02, 32'h0BADF00D);
    Reset = 1;
    exp_q.delete();
    model_mem[2] = tb_mem[2];
    step(); step();
    Reset = 0;
    for (int k = 0; k < 8; k++) begin
      check("rst_mid_quiet", {RspValid, MemValid}, 0);
      step();
    end
    check("rst_mid_busy", Busy, 0);
    check("rst_mid_ready", ReqReady, 1);
    check("rst_mid_mem2", tb_mem[2], model_mem[2]);

`ifdef MEM_REQ_CTRL_VERIFY_EN
    corrupt = 1;
    push(1, 8'h05, 32'hDEADBEEF);
    wait_idle();
    check("verr_set", VerifyErr, 1);
    corrupt = 0;
    push(1, 8'h06, 32'hCAFEF00D);
    wait_idle();
    check("verr_sticky", VerifyErr, 1);
    Reset = 1;
    step();
    Reset = 0;
    check("verr_cleared", VerifyErr, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
